// File: rtl/load_pkg.sv
// Shared load-unit definitions: load-type codes, access-size table and FSM state encoding.
package load_pkg;

    localparam int unsigned TYPE_W = 3;
    localparam int unsigned SIZE_W = 4;

    typedef enum logic [TYPE_W-1:0] {
        LT_LB   = 3'd0,
        LT_LBU  = 3'd1,
        LT_LH   = 3'd2,
        LT_LHU  = 3'd3,
        LT_LW   = 3'd4,
        LT_LWU  = 3'd5,
        LT_LD   = 3'd6,
        LT_RSVD = 3'd7
    } load_type_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    // Access size in bytes; zero for the reserved code.
    function automatic logic [SIZE_W-1:0] load_size(input logic [TYPE_W-1:0] t);
        case (t)
            LT_LB, LT_LBU:  return SIZE_W'(1);
            LT_LH, LT_LHU:  return SIZE_W'(2);
            LT_LW, LT_LWU:  return SIZE_W'(4);
            LT_LD:          return SIZE_W'(8);
            default:        return SIZE_W'(0);
        endcase
    endfunction

    function automatic logic load_signed(input logic [TYPE_W-1:0] t);
        return (t == LT_LB) || (t == LT_LH) || (t == LT_LW);
    endfunction

    // LWU/LD only make sense when the word is wider than 32 bits.
    function automatic logic load_supported(input logic [TYPE_W-1:0] t, input int unsigned data_w);
        if (t == LT_RSVD) return 1'b0;
        if ((data_w < 32'd64) && ((t == LT_LWU) || (t == LT_LD))) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/load_align_unit_if.sv
// Request, memory-read and response signal bundle of the load align unit.
interface load_align_unit_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_type;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_misalign;

    // The unit itself.
    modport slave (
        input  req_valid, req_addr, req_type, mem_gnt, mem_rvalid, mem_rdata, rsp_ready,
        output req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_misalign
    );

    // Requester, memory and consumer side.
    modport master (
        output req_valid, req_addr, req_type, mem_gnt, mem_rvalid, mem_rdata, rsp_ready,
        input  req_ready, mem_req, mem_addr, rsp_valid, rsp_data, rsp_misalign
    );
endinterface

// File: rtl/load_extract.sv
// Combinational byte-lane shift, size mask and sign/zero extension of a loaded word pair.
module load_extract
    import load_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]              word_lo,
    input  logic [DATA_W-1:0]              word_hi,
    input  logic [$clog2(DATA_W/8)-1:0]    offset,
    input  logic [TYPE_W-1:0]              load_type,
    output logic [DATA_W-1:0]              result
);
    localparam int unsigned IDX_W = $clog2(2 * DATA_W);

    logic [2*DATA_W-1:0] shifted;
    logic [DATA_W-1:0]   keep;
    logic [IDX_W-1:0]    msb_idx;
    int unsigned         nbits;
    logic                fill;

    always_comb begin
        shifted = {word_hi, word_lo} >> {offset, 3'b000};
        nbits   = 32'(load_size(load_type)) * 32'd8;
        msb_idx = (nbits == 32'd0) ? '0 : IDX_W'(nbits - 32'd1);
        fill    = load_signed(load_type) & shifted[msb_idx];
        // Shifting by DATA_W or more yields zero, so full-width loads keep every bit.
        keep    = ~({DATA_W{1'b1}} << nbits);
        result  = (shifted[DATA_W-1:0] & keep) | (~keep & {DATA_W{fill}});
    end

endmodule

// File: rtl/load_align_unit.sv
// Load align unit: fetches one or two aligned words and returns the extended load result.
// Define LOAD_UNALIGNED_SPLIT_EN to serve word-crossing loads with two reads instead of faulting.
module load_align_unit
    import load_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    load_align_unit_if.slave bus
);
    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);

    state_t            state_q, state_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [TYPE_W-1:0] type_q, type_d;
    logic [DATA_W-1:0] word0_q, word0_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_mis_q, rsp_mis_d;
    logic              req_ready_q, mem_req_q, rsp_valid_q;

    logic [OFF_W-1:0]  req_off;
    logic [ADDR_W-1:0] req_aligned;
    logic              req_supported;
    logic              req_fault;
    logic [DATA_W-1:0] ext_lo, ext_result;

    assign req_off       = bus.req_addr[OFF_W-1:0];
    assign req_aligned   = {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign req_supported = load_supported(bus.req_type, DATA_W);

`ifdef LOAD_UNALIGNED_SPLIT_EN
    logic q_split;

    assign req_fault = 1'b0;
    assign q_split   = (32'(off_q) + 32'(load_size(type_q))) > BYTES;
`else
    logic [SIZE_W-1:0] req_size;
    logic              req_split, req_unaligned;

    // Without split support any word-crossing or naturally misaligned load faults.
    assign req_size      = load_size(bus.req_type);
    assign req_split     = (32'(req_off) + 32'(req_size)) > BYTES;
    assign req_unaligned = (32'(req_off) & (32'(req_size) - 32'd1)) != 32'd0;
    assign req_fault     = req_split | req_unaligned;
`endif

    // Second word's low half comes from the first read; single reads use the live word.
    assign ext_lo = (state_q == ST_WAIT1) ? word0_q : bus.mem_rdata;

    load_extract #(.DATA_W(DATA_W)) u_extract (
        .word_lo   (ext_lo),
        .word_hi   (bus.mem_rdata),
        .offset    (off_q),
        .load_type (type_q),
        .result    (ext_result)
    );

    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        type_d     = type_q;
        word0_d    = word0_q;
        mem_addr_d = mem_addr_q;
        rsp_data_d = rsp_data_q;
        rsp_mis_d  = rsp_mis_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    off_d      = req_off;
                    type_d     = bus.req_type;
                    mem_addr_d = req_aligned;
                    if (!req_supported) begin
                        state_d    = ST_RESP;
                        rsp_data_d = '0;
                        rsp_mis_d  = 1'b0;
                    end else if (req_fault) begin
                        state_d    = ST_RESP;
                        rsp_data_d = '0;
                        rsp_mis_d  = 1'b1;
                    end else begin
                        state_d = ST_REQ0;
                    end
                end
            end
            ST_REQ0: begin
                if (bus.mem_gnt) state_d = ST_WAIT0;
            end
            ST_WAIT0: begin
                if (bus.mem_rvalid) begin
                    word0_d    = bus.mem_rdata;
                    state_d    = ST_RESP;
                    rsp_data_d = ext_result;
                    rsp_mis_d  = 1'b0;
`ifdef LOAD_UNALIGNED_SPLIT_EN
                    if (q_split) begin
                        state_d    = ST_REQ1;
                        rsp_data_d = rsp_data_q;
                        mem_addr_d = mem_addr_q + ADDR_W'(BYTES);
                    end
`endif
                end
            end
            ST_REQ1: begin
                if (bus.mem_gnt) state_d = ST_WAIT1;
            end
            ST_WAIT1: begin
                if (bus.mem_rvalid) begin
                    state_d    = ST_RESP;
                    rsp_data_d = ext_result;
                    rsp_mis_d  = 1'b0;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered decodes of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            off_q       <= '0;
            type_q      <= '0;
            word0_q     <= '0;
            mem_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_mis_q   <= 1'b0;
            req_ready_q <= 1'b1;
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            type_q      <= type_d;
            word0_q     <= word0_d;
            mem_addr_q  <= mem_addr_d;
            rsp_data_q  <= rsp_data_d;
            rsp_mis_q   <= rsp_mis_d;
            req_ready_q <= (state_d == ST_IDLE);
            mem_req_q   <= (state_d == ST_REQ0) || (state_d == ST_REQ1);
            rsp_valid_q <= (state_d == ST_RESP);
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_misalign = rsp_mis_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit on a 32-bit and a 64-bit instance with a response scoreboard.
// Expectations follow LOAD_UNALIGNED_SPLIT_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_load_align_unit;
    import load_pkg::*;

    typedef struct packed {
        logic [63:0] data;
        logic        misalign;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    load_align_unit_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
    load_align_unit_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

    load_align_unit #(.DATA_W(32), .ADDR_W(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
    load_align_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (.clk(clk), .rst(rst), .bus(b64.slave));

    rsp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t pop_expected(input string tag);
        rsp_t r;
        r = '0;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: scoreboard empty, observed response expected none", tag);
        end else begin
            r = sb.pop_front();
        end
        return r;
    endfunction

    // One load on the 32-bit unit: nreads memory reads at a0/a1, optional grant and ready stalls.
    task automatic load32(input string tag, input logic [31:0] addr, input logic [2:0] typ,
                          input int nreads, input logic [31:0] a0, input logic [31:0] w0,
                          input logic [31:0] a1, input logic [31:0] w1,
                          input int gnt_wait, input int rsp_wait,
                          input logic [31:0] exp_data, input logic exp_mis);
        logic [31:0] addrs[2];
        logic [31:0] words[2];
        rsp_t        r;
        int          n;
        addrs[0] = a0; addrs[1] = a1;
        words[0] = w0; words[1] = w1;
        check({tag, " req_ready"}, 64'(b32.req_ready), 64'd1);
        b32.req_valid = 1'b1;
        b32.req_addr  = addr;
        b32.req_type  = typ;
        r.data = 64'(exp_data);
        r.misalign = exp_mis;
        sb.push_back(r);
        @(negedge clk);
        b32.req_valid = 1'b0;
        for (int i = 0; i < nreads; i++) begin
            check({tag, " mem_req"}, 64'(b32.mem_req), 64'd1);
            check({tag, " mem_addr"}, 64'(b32.mem_addr), 64'(addrs[i]));
            for (int g = 0; g < gnt_wait; g++) begin
                @(negedge clk);
                check({tag, " mem_req held"}, 64'(b32.mem_req), 64'd1);
                check({tag, " mem_addr held"}, 64'(b32.mem_addr), 64'(addrs[i]));
            end
            b32.mem_gnt = 1'b1;
            @(negedge clk);
            b32.mem_gnt = 1'b0;
            check({tag, " mem_req after gnt"}, 64'(b32.mem_req), 64'd0);
            b32.mem_rvalid = 1'b1;
            b32.mem_rdata  = words[i];
            @(negedge clk);
            b32.mem_rvalid = 1'b0;
            b32.mem_rdata  = '0;
        end
        if (nreads == 0) check({tag, " no mem_req"}, 64'(b32.mem_req), 64'd0);
        check({tag, " rsp latency"}, 64'(b32.rsp_valid), 64'd1);
        n = 0;
        while (!b32.rsp_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!b32.rsp_valid) begin
            check({tag, " rsp timeout"}, 64'(b32.rsp_valid), 64'd1);
            void'(pop_expected(tag));
            return;
        end
        r = pop_expected(tag);
        check({tag, " rsp_data"}, 64'(b32.rsp_data), r.data);
        check({tag, " rsp_misalign"}, 64'(b32.rsp_misalign), 64'(r.misalign));
        for (int k = 0; k < rsp_wait; k++) begin
            @(negedge clk);
            check({tag, " rsp_valid held"}, 64'(b32.rsp_valid), 64'd1);
            check({tag, " rsp_data held"}, 64'(b32.rsp_data), r.data);
        end
        b32.rsp_ready = 1'b1;
        @(negedge clk);
        b32.rsp_ready = 1'b0;
        check({tag, " rsp_valid drop"}, 64'(b32.rsp_valid), 64'd0);
    endtask

    // Single-read load on the 64-bit unit at minimum latency.
    task automatic load64(input string tag, input logic [31:0] addr, input logic [2:0] typ,
                          input logic [31:0] maddr, input logic [63:0] w, input logic [63:0] exp_data);
        rsp_t r;
        r.data = exp_data;
        r.misalign = 1'b0;
        b64.req_valid = 1'b1;
        b64.req_addr  = addr;
        b64.req_type  = typ;
        sb.push_back(r);
        @(negedge clk);
        b64.req_valid = 1'b0;
        check({tag, " mem_req"}, 64'(b64.mem_req), 64'd1);
        check({tag, " mem_addr"}, 64'(b64.mem_addr), 64'(maddr));
        b64.mem_gnt = 1'b1;
        @(negedge clk);
        b64.mem_gnt    = 1'b0;
        b64.mem_rvalid = 1'b1;
        b64.mem_rdata  = w;
        @(negedge clk);
        b64.mem_rvalid = 1'b0;
        check({tag, " rsp_valid"}, 64'(b64.rsp_valid), 64'd1);
        r = pop_expected(tag);
        check({tag, " rsp_data"}, b64.rsp_data, r.data);
        check({tag, " rsp_misalign"}, 64'(b64.rsp_misalign), 64'(r.misalign));
        b64.rsp_ready = 1'b1;
        @(negedge clk);
        b64.rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        logic [7:0]  byte_v;

        rst = 1'b1;
        b32.req_valid = 1'b0; b32.req_addr = '0; b32.req_type = '0;
        b32.mem_gnt = 1'b0; b32.mem_rvalid = 1'b0; b32.mem_rdata = '0; b32.rsp_ready = 1'b0;
        b64.req_valid = 1'b0; b64.req_addr = '0; b64.req_type = '0;
        b64.mem_gnt = 1'b0; b64.mem_rvalid = 1'b0; b64.mem_rdata = '0; b64.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        check("reset req_ready", 64'(b32.req_ready), 64'd1);
        check("reset mem_req", 64'(b32.mem_req), 64'd0);
        check("reset rsp_valid", 64'(b32.rsp_valid), 64'd0);
        check("reset rsp_data", 64'(b32.rsp_data), 64'd0);
        check("reset rsp_misalign", 64'(b32.rsp_misalign), 64'd0);
        check("reset mem_addr", 64'(b32.mem_addr), 64'd0);
        check("reset64 rsp_data", b64.rsp_data, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        load32("lb_3", 32'h1003, LT_LB, 1, 32'h1000, 32'h80FF1234, 0, 0, 0, 0, 32'hFFFFFF80, 1'b0);
        load32("lhu_2", 32'h1002, LT_LHU, 1, 32'h1000, 32'hBEEF0000, 0, 0, 0, 0, 32'h0000BEEF, 1'b0);
        load32("lh_2", 32'h1002, LT_LH, 1, 32'h1000, 32'hBEEF0000, 0, 0, 0, 0, 32'hFFFFBEEF, 1'b0);
        load32("lw_0", 32'h1000, LT_LW, 1, 32'h1000, 32'h87654321, 0, 0, 0, 0, 32'h87654321, 1'b0);
        load32("lbu_stall", 32'h2002, LT_LBU, 1, 32'h2000, 32'h00A50000, 0, 0, 3, 2, 32'h000000A5, 1'b0);
        load32("rsvd", 32'h1000, 3'd7, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1'b0);
        load32("lwu_32", 32'h1000, LT_LWU, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1'b0);
        load32("ld_32", 32'h1000, LT_LD, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1'b0);

`ifdef LOAD_UNALIGNED_SPLIT_EN
        load32("lw_split", 32'h1002, LT_LW, 2, 32'h1000, 32'h44332211, 32'h1004, 32'h88776655,
               1, 1, 32'h66554433, 1'b0);
        load32("lhu_split", 32'h1003, LT_LHU, 2, 32'h1000, 32'hAB000000, 32'h1004, 32'h000000CD,
               0, 0, 32'h0000CDAB, 1'b0);
        load32("lh_odd", 32'h1001, LT_LH, 1, 32'h1000, 32'h00800100, 0, 0, 0, 0, 32'hFFFF8001, 1'b0);
`else
        load32("lw_split", 32'h1002, LT_LW, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1'b1);
        load32("lhu_split", 32'h1003, LT_LHU, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1'b1);
        load32("lh_odd", 32'h1001, LT_LH, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1'b1);
`endif

        // Byte lanes across every offset, zero- and sign-extended.
        for (int off = 0; off < 4; off++) begin
            w = $urandom;
            byte_v = 8'(w >> (8 * off));
            load32("lbu_lane", 32'h5000 + 32'(off), LT_LBU, 1, 32'h5000, w, 0, 0, 0, 0,
                   {24'h0, byte_v}, 1'b0);
            load32("lb_lane", 32'h5000 + 32'(off), LT_LB, 1, 32'h5000, w, 0, 0, 0, 0,
                   {{24{byte_v[7]}}, byte_v}, 1'b0);
        end

        // Reset while waiting for read data drops the transaction.
        b32.req_valid = 1'b1; b32.req_addr = 32'h3001; b32.req_type = LT_LBU;
        @(negedge clk);
        b32.req_valid = 1'b0;
        check("abort mem_req", 64'(b32.mem_req), 64'd1);
        b32.mem_gnt = 1'b1;
        @(negedge clk);
        b32.mem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        check("abort rst mem_req", 64'(b32.mem_req), 64'd0);
        check("abort rst rsp_valid", 64'(b32.rsp_valid), 64'd0);
        check("abort rst req_ready", 64'(b32.req_ready), 64'd1);
        check("abort rst mem_addr", 64'(b32.mem_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        b32.mem_rvalid = 1'b1; b32.mem_rdata = 32'h12345678;
        @(negedge clk);
        b32.mem_rvalid = 1'b0;
        check("late rvalid rsp_valid", 64'(b32.rsp_valid), 64'd0);
        check("late rvalid req_ready", 64'(b32.req_ready), 64'd1);
        check("late rvalid mem_req", 64'(b32.mem_req), 64'd0);
        load32("lbu_after_rst", 32'h3001, LT_LBU, 1, 32'h3000, 32'h0000C300, 0, 0, 0, 0, 32'h000000C3, 1'b0);

        load64("lwu64", 32'h4, LT_LWU, 32'h0, 64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF);
        load64("lw64", 32'h4, LT_LW, 32'h0, 64'hFFFFFFFF00000000, 64'hFFFFFFFFFFFFFFFF);
        load64("ld64", 32'h8, LT_LD, 32'h8, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF);
        load64("lb64", 32'h17, LT_LB, 32'h10, 64'h7F00000000000000, 64'h000000000000007F);

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
